fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one cyclic FIFO's write side among NREQ producer blocks. The arbiter grants one producer at a time for a bounded burst, drives the FIFO's wr/data_in directly, and stalls on FIFO full. It sits between the project's producer blocks and the FIFO instance; the FIFO read side is untouched.

Parameters:
NREQ, 4, number of requesters (2..16)
dat_width, 8, data word width; must equal the FIFO dat_width
max_burst, 4, maximum words written per grant (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester write request; bit i = requester i
req_data  input  NREQ*dat_width  flattened words; requester i at bits [i*dat_width +: dat_width]
ack  output  NREQ  one-hot; bit i high in the cycle requester i's word is written
fifo_full  input  1  FIFO full flag
fifo_wr  output  1  FIFO write strobe
fifo_data  output  dat_width  FIFO data_in
owner  output  ID_W  current grant index, ID_W = clog2(NREQ)
busy  output  1  high while in BURST

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All state registers use posedge clk, posedge reset.
- Reset values:
  - state=IDLE, owner=0, last_owner=NREQ-1 (requester 0 wins first), burst_cnt=0.
  - busy=0, fifo_wr=0, ack=0; fifo_data = req_data of requester 0 (don't-care).
- States:
  - IDLE: if |req, next state BURST. Owner is the first requester with req set, searching cyclically from last_owner+1. Otherwise stay in IDLE.
  - BURST: fifo_wr = req[owner] & ~fifo_full (combinational). ack[owner] = fifo_wr. fifo_data = req_data[owner].
- Burst counting and release:
  - burst_cnt increments on each fifo_wr.
  - Release when ~req[owner], or when fifo_wr with burst_cnt == max_burst-1.
  - On release: last_owner <= owner and burst_cnt <= 0. Re-arbitrate in the same cycle from owner+1 using current req.
  - If any request is set, go directly to BURST with the new owner (no idle bubble). Otherwise go to IDLE.
  - The releasing owner has lowest priority. If it still requests and no one else does, it is re-granted.
- Latency:
  - A request seen in IDLE at edge t gets its first write in cycle t+1, provided the FIFO is not full.
  - Back-to-back owners produce continuous writes.
- Full: while fifo_full=1, fifo_wr=0 and ack=0. Owner and burst_cnt hold; stalled cycles are not counted. There is no timeout; the burst resumes when full deasserts.
- Requester protocol:
  - Hold req_data stable while req is high until ack.
  - The next word may be presented in the cycle after ack.
  - req may drop at any time with no word lost; a non-acked word is simply not written.
- The arbiter never asserts fifo_wr while fifo_full=1, so no word is dropped by the FIFO.
- Reset mid-burst: state clears immediately and fifo_wr deasserts asynchronously. The partially written burst remains in the FIFO.
- Width rules: burst_cnt width = clog2(max_burst+1). owner arithmetic is modulo NREQ; wrap from NREQ-1 to 0.

Decomposition:
- Shared package fifo_arb_pkg:
  - state encoding localparams (IDLE=1'b0, BURST=1'b1)
  - clog2 constant function, reused for ID_W and burst_cnt width
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: valid, winning index.
  - Instanced once, used for both IDLE grant and release re-arbitration.

Test Plan:
- Reset, then req=4'b0001 continuously with 6 words (max_burst=4):
  - words 0-3 written on consecutive cycles, ack[0] each cycle;
  - release, then re-grant to 0 with no idle cycle;
  - words 4-5 follow; FIFO contents in order.
- req=4'b1111 held, each requester streaming its own id:
  - grant order 0,1,2,3,0, 4 words each;
  - fifo_wr continuous;
  - owner sequence checked cycle by cycle.
- Owner 2 in BURST, fifo_full forced high 5 cycles after word 1:
  - fifo_wr=0, ack=0 during the stall; owner=2 and burst_cnt=2 held;
  - words 2-3 written after full clears, then release.
- Owner 1 drops req after 2 words while req[3]=1:
  - next cycle owner=3, burst_cnt=0;
  - requester 1's third word is never written.
- Assert reset mid-burst (owner=2, burst_cnt=1):
  - fifo_wr low immediately, busy=0, owner=0;
  - after release with req=4'b0100, the next grant goes to requester 2 in cycle t+1.
- FIFO (adr_width=4) filled to 16 by two requesters:
  - full asserted, no further fifo_wr;
  - one read per cycle from the sink, then writes resume interleaved;
  - no data loss or duplication checked by a scoreboard.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding and
// the ceil-log2 helper used to size the owner index and burst counter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Ceil(log2(value)); callers always pass value >= 2.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request found by
// searching cyclically from last+1, so the index 'last' has lowest priority.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  logic [ID_W-1:0] cand;

  // Walk from the farthest distance to the nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int d = int'(NREQ); d >= 1; d--) begin
      cand = ID_W'((int'(last) + d) % int'(NREQ));
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A granted producer writes up to max_burst words; stalls on fifo_full;
// release re-arbitrates in the same cycle so owners hand over without a bubble.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned dat_width = 8,
  parameter  int unsigned max_burst = 4,
  localparam int unsigned ID_W      = clog2(NREQ),
  localparam int unsigned CNT_W     = clog2(max_burst + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*dat_width-1:0] req_data,
  output logic [NREQ-1:0]           ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [dat_width-1:0]      fifo_data,
  output logic [ID_W-1:0]           owner,
  output logic                      busy
);

  arb_state_t       state;
  logic [ID_W-1:0]  last_owner;
  logic [CNT_W-1:0] burst_cnt;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic [ID_W-1:0]  pick_last;
  logic             last_word;
  logic             release_grant;

  // In IDLE search after the previous owner; on release search after the
  // current owner, which becomes last_owner in the same edge.
  assign pick_last = (state == BURST) ? owner : last_owner;

  rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_pick (
    .req   (req),
    .last  (pick_last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Write strobe is combinational so reset and fifo_full take effect at once.
  assign fifo_wr       = (state == BURST) & req[owner] & ~fifo_full;
  assign ack           = fifo_wr ? (NREQ'(1) << owner) : '0;
  assign fifo_data     = req_data[owner*dat_width +: dat_width];
  assign busy          = (state == BURST);
  assign last_word     = (burst_cnt == CNT_W'(max_burst - 1));
  assign release_grant = ~req[owner] | (fifo_wr & last_word);

  // Grant state machine: idle arbitration, burst counting and release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= ID_W'(NREQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= BURST;
            owner     <= pick_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (release_grant) begin
            last_owner <= owner;
            burst_cnt  <= '0;
            if (pick_valid) begin
              owner <= pick_idx;
            end else begin
              state <= IDLE;
            end
          end else if (fifo_wr) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed phases plus random traffic,
// a grant-level reference model, and a 16-deep FIFO sink with an order scoreboard.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int MAXB  = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   ack;
  logic              fifo_full = 1'b0;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_data;
  logic [1:0]        owner;
  logic              busy;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .dat_width (DW),
    .max_burst (MAXB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .owner     (owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Requester, sink and scoreboard state.
  int         rem[NREQ];
  bit         drop[NREQ];
  logic [5:0] seq[NREQ];
  logic [5:0] rd_seq[NREQ];
  logic [7:0] sink[$];
  bit         force_full;
  bit         rd_en;
  int         total_wr;
  int         total_rd;
  int         checks;
  int         errors;

  // Grant-level reference model.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_words;

  bit wr_log[$];
  int own_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [NREQ-1:0] r, input int last);
    for (int d = 1; d <= NREQ; d++) begin
      if (r[(last + d) % NREQ]) return (last + d) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] log_pat();
    logic [31:0] p;
    p = '0;
    foreach (wr_log[k]) if (k < 32 && wr_log[k]) p[k] = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NREQ - 1;
    m_words = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = (rem[i] > 0) && !drop[i];
      req_data[i*DW +: DW] = {2'(i), seq[i]};
    end
    fifo_full = force_full || (sink.size() >= DEPTH);
  endtask

  task automatic pop_check();
    logic [7:0] w;
    int id;
    w  = sink.pop_front();
    id = int'(w[7:6]);
    chk("scoreboard_order", {26'd0, w[5:0]}, {26'd0, rd_seq[id]});
    rd_seq[id]++;
    total_rd++;
  endtask

  // One clock: drive at posedge+1, compare at negedge, update at posedge.
  task automatic cycle();
    bit          ewr;
    logic [3:0]  sack;
    bit          swr;
    logic [7:0]  sdat;
    logic [1:0]  own2;
    int          nxt;
    drive();
    @(negedge clk);
    own2 = 2'(m_owner);
    ewr  = !reset && m_busy && req[m_owner] && !fifo_full;
    chk("busy", {31'd0, busy}, {31'd0, m_busy && !reset});
    chk("fifo_wr", {31'd0, fifo_wr}, {31'd0, ewr});
    chk("ack", {28'd0, ack}, ewr ? (32'd1 << m_owner) : 32'd0);
    if (reset || m_busy) chk("owner", {30'd0, owner}, reset ? 32'd0 : {30'd0, own2});
    if (ewr) chk("fifo_data", {24'd0, fifo_data}, {24'd0, own2, seq[m_owner]});
    wr_log.push_back(ewr);
    if (ewr) own_log.push_back(m_owner);
    swr  = (fifo_wr === 1'b1);
    sack = ack;
    sdat = fifo_data;
    @(posedge clk);
    if (rd_en && sink.size() > 0) pop_check();
    if (swr) begin
      sink.push_back(sdat);
      total_wr++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (sack[i] === 1'b1) begin
        seq[i]++;
        if (rem[i] > 0) rem[i]--;
      end
    end
    if (reset) begin
      model_reset();
    end else if (!m_busy) begin
      nxt = rr_next(req, m_last);
      if (nxt >= 0) begin
        m_busy  = 1'b1;
        m_owner = nxt;
        m_words = 0;
      end
    end else begin
      if (ewr) m_words++;
      if (!req[m_owner] || m_words == MAXB) begin
        m_last  = m_owner;
        m_words = 0;
        nxt     = rr_next(req, m_owner);
        if (nxt >= 0) m_owner = nxt;
        else m_busy = 1'b0;
      end
    end
    #1;
  endtask

  // Reset, drain the sink through the scoreboard and clear stimulus.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    rd_en = 1'b1;
    force_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = 0;
      drop[i] = 1'b0;
    end
    cycle();
    for (int n = 0; n < 40 && sink.size() > 0; n++) cycle();
    cycle();
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
    reset = 1'b0;
    rd_en = 1'b0;
    wr_log.delete();
    own_log.delete();
  endtask

  logic [5:0] s1, s3;
  int         cnt;

  initial begin
    checks = 0;
    errors = 0;
    total_wr = 0;
    total_rd = 0;
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = '0;
      rd_seq[i] = '0;
    end
    model_reset();

    // A: single requester, 6 words, burst of 4 then immediate re-grant.
    do_reset();
    rem[0] = 6;
    repeat (9) cycle();
    chk("A_wr_pattern", log_pat(), 32'h0000_007E);
    chk("A_sink_size", sink.size(), 32'd6);
    for (int k = 0; k < 6 && k < sink.size(); k++) chk("A_sink_word", {24'd0, sink[k]}, k);

    // B: all requesters streaming; owners 0,1,2,3,0 four words each.
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < NREQ; i++) rem[i] = 1000;
    repeat (22) cycle();
    chk("B_wr_continuous", log_pat() & 32'h001F_FFFE, 32'h001F_FFFE);
    for (int k = 0; k < 20 && k < own_log.size(); k++) chk("B_owner_seq", own_log[k], (k / 4) % 4);

    // C: owner 2 stalled by fifo_full for 5 cycles after its second word.
    do_reset();
    rd_en = 1'b1;
    rem[2] = 4;
    for (int k = 0; k < 11; k++) begin
      force_full = (k >= 3 && k <= 7);
      cycle();
    end
    force_full = 1'b0;
    chk("C_wr_pattern", log_pat(), 32'h0000_0306);
    chk("C_words", own_log.size(), 32'd4);

    // D: owner 1 drops after two words while requester 3 waits.
    do_reset();
    s1 = seq[1];
    s3 = seq[3];
    rem[1] = 2;
    rem[3] = 3;
    repeat (8) cycle();
    chk("D_wr_pattern", log_pat(), 32'h0000_0076);
    chk("D_sink_size", sink.size(), 32'd5);
    if (sink.size() == 5) begin
      chk("D_w0", {24'd0, sink[0]}, {24'd0, 2'd1, s1});
      chk("D_w1", {24'd0, sink[1]}, {24'd0, 2'd1, s1 + 6'd1});
      chk("D_w2", {24'd0, sink[2]}, {24'd0, 2'd3, s3});
      chk("D_w3", {24'd0, sink[3]}, {24'd0, 2'd3, s3 + 6'd1});
      chk("D_w4", {24'd0, sink[4]}, {24'd0, 2'd3, s3 + 6'd2});
    end
    chk("D_owner_after_drop", own_log.size() > 2 ? own_log[2] : -1, 32'd3);

    // E: asynchronous reset in the middle of owner 2's burst.
    do_reset();
    rem[2] = 10;
    cycle();
    cycle();
    drive();
    #2;
    chk("E_pre_wr", {31'd0, fifo_wr}, 32'd1);
    reset = 1'b1;
    #1;
    chk("E_async_wr", {31'd0, fifo_wr}, 32'd0);
    chk("E_async_busy", {31'd0, busy}, 32'd0);
    chk("E_async_owner", {30'd0, owner}, 32'd0);
    chk("E_async_ack", {28'd0, ack}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_log.delete();
    own_log.delete();
    cycle();
    cycle();
    chk("E_regrant_pattern", log_pat(), 32'h0000_0002);
    chk("E_regrant_owner", own_log.size() > 0 ? own_log[0] : -1, 32'd2);

    // F: two requesters fill the 16-deep FIFO, then the sink drains one per cycle.
    do_reset();
    rem[0] = 40;
    rem[1] = 40;
    repeat (40) cycle();
    chk("F_sink_full", sink.size(), DEPTH);
    cnt = 0;
    for (int k = 30; k < 40; k++) if (wr_log[k]) cnt++;
    chk("F_no_wr_when_full", cnt, 32'd0);
    for (int k = 0; k < 16 && k < own_log.size(); k++) chk("F_interleave", own_log[k], (k / 4) % 2);
    rd_en = 1'b1;
    repeat (60) cycle();

    // G: random traffic, drops, forced stalls and random reads.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom % 4 == 0) rem[i] = int'($urandom_range(8, 1));
        drop[i] = ($urandom % 8 == 0);
      end
      force_full = ($urandom % 6 == 0);
      rd_en = ($urandom % 2 == 0);
      cycle();
    end

    do_reset();
    chk("final_sink_empty", sink.size(), 32'd0);
    chk("final_balance", total_rd, total_wr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
